// File: rtl/ysyx_25070198_bus_pkg.sv
// Shared types and constants for the SimpleBus memory arbiter.
//   arb_state_t : arbiter sequencing states (IDLE -> REQ -> WAIT)
//   owner_t     : which master owns the current access
//   ERR_RDATA_DEFAULT / TIMEOUT_CYC_DEFAULT : default parameter values
package ysyx_25070198_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT   = 32'hDEADBEEF;
  localparam int unsigned TIMEOUT_CYC_DEFAULT = 256;

endpackage

// File: rtl/ysyx_25070198_arb_timeout.sv
// Watchdog counter for the arbiter WAIT phase.
//   clk_i    : clock
//   rst_i    : synchronous active-low reset
//   clr_i    : force the count to zero
//   en_i     : count one cycle
//   expire_o : en_i is set and the count has reached TIMEOUT_CYC-1
module ysyx_25070198_arb_timeout #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST; the arbiter leaves WAIT on expiry anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_25070198_mem_arbiter.sv
// Shares one SimpleBus memory port between the IFU (read-only) and the LSU.
// Each access runs IDLE (arbitrate) -> REQ (address phase) -> WAIT (response),
// and the response is routed to the registered owner. A watchdog aborts a WAIT
// that never sees mem_resp_i, returning ERR_RDATA and pulsing bus_err_o.
// Optional build macro YSYX_ARB_RR_EN: round-robin arbitration instead of
// fixed LSU priority.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   ifu_req_i/ifu_addr_i -> ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o
//   lsu_req_i/lsu_wen_i/lsu_addr_i/lsu_wdata_i/lsu_wmask_i
//                        -> lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o
//   mem_req_o/mem_wen_o/mem_addr_o/mem_wdata_o/mem_wmask_o, mem_ready_i,
//   mem_resp_i/mem_rdata_i
//   bus_err_o (timeout pulse), busy_o (not IDLE)
module ysyx_25070198_mem_arbiter
  import ysyx_25070198_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ifu_req_i,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_gnt_o,
  output logic        ifu_rvalid_o,
  output logic [31:0] ifu_rdata_o,
  input  logic        lsu_req_i,
  input  logic        lsu_wen_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wmask_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_req_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_ready_i,
  input  logic        mem_resp_i,
  input  logic [31:0] mem_rdata_i,
  output logic        bus_err_o,
  output logic        busy_o
);

  arb_state_t state_q, state_d;
  owner_t     owner_q, owner_d, pick;
  logic       wen_q, wen_d;
  logic       owner_req, in_req, in_wait, gnt, resp, tmo, done, expire;
  logic       own_lsu;
  logic [31:0] rsp_data;

  // Outputs are gated by rst_i so everything reads 0 while reset is held.
  assign in_req    = rst_i && (state_q == REQ);
  assign in_wait   = rst_i && (state_q == WAIT);
  assign own_lsu   = (owner_q == OWN_LSU);
  assign owner_req = own_lsu ? lsu_req_i : ifu_req_i;
  assign gnt       = in_req && mem_ready_i && owner_req;
  assign resp      = in_wait && mem_resp_i;
  assign tmo       = in_wait && !mem_resp_i && expire;
  assign done      = resp || tmo;

`ifdef YSYX_ARB_RR_EN
  // Last granted master; on a tie the other one wins.
  owner_t rr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_q <= OWN_IFU;
    end else if (gnt) begin
      rr_q <= owner_q;
    end
  end

  always_comb begin
    pick = lsu_req_i ? OWN_LSU : OWN_IFU;
    if (lsu_req_i && ifu_req_i) begin
      pick = (rr_q == OWN_LSU) ? OWN_IFU : OWN_LSU;
    end
  end
`else
  assign pick = lsu_req_i ? OWN_LSU : OWN_IFU;
`endif

  ysyx_25070198_arb_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (state_q != WAIT),
    .en_i    (state_q == WAIT),
    .expire_o(expire)
  );

  // Next-state: owner is latched in IDLE and frozen until the access completes.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wen_d   = wen_q;
    case (state_q)
      IDLE: begin
        if (ifu_req_i || lsu_req_i) begin
          state_d = REQ;
          owner_d = pick;
        end
      end
      REQ: begin
        if (gnt) begin
          state_d = WAIT;
          wen_d   = own_lsu && lsu_wen_i;
        end
      end
      WAIT: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wen_q   <= wen_d;
    end
  end

  // Response data: memory data wins over a same-cycle timeout.
  assign rsp_data = resp ? mem_rdata_i : ERR_RDATA;

  always_comb begin
    mem_req_o    = in_req;
    mem_wen_o    = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_wmask_o  = '0;
    ifu_gnt_o    = gnt && !own_lsu;
    lsu_gnt_o    = gnt && own_lsu;
    ifu_rvalid_o = done && !own_lsu;
    lsu_rvalid_o = done && own_lsu;
    ifu_rdata_o  = '0;
    lsu_rdata_o  = '0;
    bus_err_o    = tmo;
    busy_o       = rst_i && (state_q != IDLE);
    if (in_req) begin
      if (own_lsu) begin
        mem_wen_o   = lsu_wen_i;
        mem_addr_o  = lsu_addr_i;
        mem_wdata_o = lsu_wdata_i;
        mem_wmask_o = lsu_wmask_i;
      end else begin
        mem_addr_o  = ifu_addr_i;
      end
    end
    if (done && !own_lsu) begin
      ifu_rdata_o = rsp_data;
    end
    // A completed store returns 0; a timed-out store still returns ERR_RDATA.
    if (done && own_lsu && !(resp && wen_q)) begin
      lsu_rdata_o = rsp_data;
    end
  end

endmodule

// File: tb/tb_ysyx_25070198_mem_arbiter.sv
// Directed, self-checking bench for ysyx_25070198_mem_arbiter (TIMEOUT_CYC=8).
module tb_ysyx_25070198_mem_arbiter;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, ifu_gnt, ifu_rvalid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req, lsu_wen, lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req, mem_wen, mem_ready, mem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        bus_err, busy;

  typedef struct {
    bit          lsu;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ysyx_25070198_mem_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ifu_req_i   (ifu_req),
    .ifu_addr_i  (ifu_addr),
    .ifu_gnt_o   (ifu_gnt),
    .ifu_rvalid_o(ifu_rvalid),
    .ifu_rdata_o (ifu_rdata),
    .lsu_req_i   (lsu_req),
    .lsu_wen_i   (lsu_wen),
    .lsu_addr_i  (lsu_addr),
    .lsu_wdata_i (lsu_wdata),
    .lsu_wmask_i (lsu_wmask),
    .lsu_gnt_o   (lsu_gnt),
    .lsu_rvalid_o(lsu_rvalid),
    .lsu_rdata_o (lsu_rdata),
    .mem_req_o   (mem_req),
    .mem_wen_o   (mem_wen),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wmask_o (mem_wmask),
    .mem_ready_i (mem_ready),
    .mem_resp_i  (mem_resp),
    .mem_rdata_i (mem_rdata),
    .bus_err_o   (bus_err),
    .busy_o      (busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge where a response is expected: pop and compare.
  task automatic check_resp();
    exp_t e;
    chk1("sb_has_entry", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk1("ifu_rvalid", ifu_rvalid, !e.lsu);
      chk1("lsu_rvalid", lsu_rvalid, e.lsu);
      chk32("rdata", e.lsu ? lsu_rdata : ifu_rdata, e.rdata);
      chk1("bus_err", bus_err, e.err);
    end
  endtask

  // Entered just after the posedge starting an IDLE cycle, requests already driven.
  // Returns just after the posedge starting the IDLE cycle that follows rvalid.
  task automatic run_access(input bit lsu, input logic [31:0] addr, input bit wen,
                            input logic [31:0] wdata, input logic [3:0] wmask,
                            input int ready_dly, input int resp_dly,
                            input logic [31:0] rdata, input bit intrude);
    exp_t e;
    mem_ready = 1'b0;
    mem_resp  = 1'b0;
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < ready_dly; i++) begin
      if (intrude && i == 1) begin
        lsu_req  = 1'b1;
        lsu_wen  = 1'b0;
        lsu_addr = 32'h8000_3000;
      end
      @(negedge clk);
      chk1("stall_mem_req", mem_req, 1'b1);
      chk32("stall_addr", mem_addr, addr);
      chk1("stall_ifu_gnt", ifu_gnt, 1'b0);
      chk1("stall_lsu_gnt", lsu_gnt, 1'b0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk1("req_mem_req", mem_req, 1'b1);
    chk32("req_addr", mem_addr, addr);
    chk1("req_wen", mem_wen, wen);
    if (wen) begin
      chk32("req_wdata", mem_wdata, wdata);
      chk32("req_wmask", 32'(mem_wmask), 32'(wmask));
    end
    chk1("ifu_gnt", ifu_gnt, !lsu);
    chk1("lsu_gnt", lsu_gnt, lsu);
    e.lsu   = lsu;
    e.rdata = wen ? 32'h0 : rdata;
    e.err   = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (lsu) lsu_req = 1'b0;
    else     ifu_req = 1'b0;
    for (int i = 0; i < resp_dly; i++) begin
      @(negedge clk);
      chk1("wait_mem_req", mem_req, 1'b0);
      chk1("wait_rvalid", ifu_rvalid | lsu_rvalid, 1'b0);
      chk1("wait_bus_err", bus_err, 1'b0);
      chk1("wait_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    check_resp();
    @(posedge clk); #1;
    mem_resp = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lsu_win;
    exp_t e;
    rst = 1'b0;
    ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_ready = 1'b1; mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;

    // Reset: all outputs quiet even with the memory side toggling.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_ifu_gnt", ifu_gnt, 1'b0);
    chk1("rst_lsu_gnt", lsu_gnt, 1'b0);
    chk1("rst_ifu_rvalid", ifu_rvalid, 1'b0);
    chk1("rst_lsu_rvalid", lsu_rvalid, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b0; mem_resp = 1'b0;

    // Simultaneous requests, three back-to-back pairs.
    for (int k = 0; k < 3; k++) begin
      ifu_req  = 1'b1; ifu_addr = 32'h8000_0100 + 32'(k * 4);
      lsu_req  = 1'b1; lsu_wen  = 1'b0; lsu_addr = 32'h8000_1000 + 32'(k * 4);
`ifdef YSYX_ARB_RR_EN
      lsu_win = (k != 1);
`else
      lsu_win = 1'b1;
`endif
      if (lsu_win)
        run_access(1'b1, lsu_addr, 1'b0, 32'h0, 4'h0, 0, 0, 32'h1111_0000 + 32'(k), 1'b0);
      else
        run_access(1'b0, ifu_addr, 1'b0, 32'h0, 4'h0, 0, 0, 32'h2222_0000 + 32'(k), 1'b0);
    end
    lsu_req = 1'b0;
    ifu_req = 1'b1; ifu_addr = 32'h8000_0200;
    run_access(1'b0, 32'h8000_0200, 1'b0, 32'h0, 4'h0, 0, 0, 32'h3333_4444, 1'b0);

    // IFU read with mem_ready low 4 cycles; LSU request mid-stall must not steal REQ.
    ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
    run_access(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 4, 0, 32'hCAFE_F00D, 1'b1);
    run_access(1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 0, 2, 32'h0BAD_C0DE, 1'b0);

    // LSU byte store.
    lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_2004;
    lsu_wdata = 32'h00AB_0000; lsu_wmask = 4'b0100;
    run_access(1'b1, 32'h8000_2004, 1'b1, 32'h00AB_0000, 4'b0100, 1, 1, 32'h5555_5555, 1'b0);
    lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;

    // mem_resp on the very cycle the watchdog would expire: data wins.
    ifu_req = 1'b1; ifu_addr = 32'h8000_0300;
    run_access(1'b0, 32'h8000_0300, 1'b0, 32'h0, 4'h0, 0, int'(TMO) - 1, 32'h7777_7777, 1'b0);

    // Timeout: no mem_resp for TMO WAIT cycles.
    ifu_req = 1'b1; ifu_addr = 32'h8000_0040;
    @(negedge clk);
    chk1("tmo_idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk1("tmo_ifu_gnt", ifu_gnt, 1'b1);
    e.lsu = 1'b0; e.rdata = 32'hDEAD_BEEF; e.err = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    mem_ready = 1'b0; ifu_req = 1'b0;
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      @(negedge clk);
      chk1("tmo_wait_rvalid", ifu_rvalid, 1'b0);
      chk1("tmo_wait_bus_err", bus_err, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_resp();
    @(posedge clk); #1;
    mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk1("late_resp_rvalid", ifu_rvalid | lsu_rvalid, 1'b0);
    chk1("late_resp_busy", busy, 1'b0);
    chk1("late_resp_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    mem_resp = 1'b0;

    // Reset asserted in WAIT: no rvalid, back to IDLE, then normal service.
    ifu_req = 1'b1; ifu_addr = 32'h8000_0080;
    @(negedge clk);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk1("rstw_ifu_gnt", ifu_gnt, 1'b1);
    @(posedge clk); #1;
    mem_ready = 1'b0; ifu_req = 1'b0;
    rst = 1'b0; mem_resp = 1'b1; mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    chk1("rstw_rvalid", ifu_rvalid | lsu_rvalid, 1'b0);
    chk1("rstw_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; mem_resp = 1'b0;
    @(negedge clk);
    chk1("rstw_idle_busy", busy, 1'b0);
    chk1("rstw_idle_rvalid", ifu_rvalid, 1'b0);
    @(posedge clk); #1;
    ifu_req = 1'b1; ifu_addr = 32'h8000_0084;
    run_access(1'b0, 32'h8000_0084, 1'b0, 32'h0, 4'h0, 0, 1, 32'h600D_600D, 1'b0);

    chk32("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
